// File: rtl/fetch_pkg.sv
// Shared types for the fetch PC unit: FSM state encoding, default address width
// and the alignment-mask helper. Used with or without the PC_RAS_EN build option.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_e;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Low address bits that must be zero for an aligned fetch address.
    function automatic logic [63:0] align_mask(int unsigned instr_bytes);
        return 64'(instr_bytes - 1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack for the fetch PC unit. Instanced only when the
// PC_RAS_EN macro is defined. A push onto a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   next_idx;

    // ptr_q points at the next free slot; the top entry sits just below it.
    always_comb begin
        top_idx  = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
        next_idx = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    assign top_o   = mem_q[top_idx];
    assign empty_o = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i && pop_i && cnt_q != '0) begin
            mem_q[top_idx] <= data_i;
        end else if (push_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= next_idx;
            if (cnt_q != CW'(DEPTH)) cnt_q <= cnt_q + 1'b1;
        end else if (pop_i && cnt_q != '0) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch program counter: handshake advance, redirect, halt/resume and
// misalignment trap. Defining PC_RAS_EN adds call/return stack support.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch issued
// RUN   | issuing fetches at pc_o
// HALT  | fetch stopped, pc held (redirect still loads pc)
// FAULT | misaligned pc loaded, waits for an aligned redirect
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned INSTR_BYTES  = 4,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    input  logic            pc_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    input  logic            resume_i,
`ifdef PC_RAS_EN
    input  logic            call_i,
    input  logic            ret_i,
    output logic            ras_underflow_o,
`endif
    output logic            misalign_o,
    output logic [1:0]      state_o
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(align_mask(INSTR_BYTES));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic            handshake;
    logic            load;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;

    assign handshake = valid_q & pc_ready_i;

`ifdef PC_RAS_EN
    logic ret_en, ras_push, ras_empty, underflow_q;

    // Returns are honoured only while fetching; a redirect in the same cycle wins.
    assign ret_en   = ret_i & ~redirect_i & (state_q == RUN);
    assign ras_push = call_i & redirect_i;
    assign ras_pop  = ret_en & ~ras_empty;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ras_push),
        .pop_i   (ras_pop | (ras_push & ret_i)),
        .data_i  (pc_q + PC_STEP),
        .top_o   (ras_top),
        .empty_o (ras_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) underflow_q <= 1'b0;
        else      underflow_q <= ret_en & ras_empty;
    end

    assign ras_underflow_o = underflow_q;
`else
    assign ras_pop = 1'b0;
    assign ras_top = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;

        if (redirect_i) begin
            pc_d = redirect_pc_i;
            load = 1'b1;
        end else if (ras_pop) begin
            pc_d = ras_top;
            load = 1'b1;
        end else if (handshake) begin
            pc_d = pc_q + PC_STEP;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_i) state_d = HALT;
            HALT:    if (resume_i && !halt_i) state_d = RUN;
            FAULT:   if (redirect_i) state_d = RUN;
            default: state_d = BOOT;
        endcase

        if (load && |(pc_d & ALIGN_MASK)) state_d = FAULT;

        valid_d    = (state_d == RUN);
        misalign_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = valid_q;
    assign misalign_o = misalign_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; the return-stack steps run when PC_RAS_EN is defined.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        pc_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        resume_i;
    logic        misalign_o;
    logic [1:0]  state_o;
`ifdef PC_RAS_EN
    logic        call_i;
    logic        ret_i;
    logic        ras_underflow_o;
`endif

    int tests  = 0;
    int failed = 0;

    fetch_pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .pc_ready_i      (pc_ready_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
`ifdef PC_RAS_EN
        .call_i          (call_i),
        .ret_i           (ret_i),
        .ras_underflow_o (ras_underflow_o),
`endif
        .misalign_o      (misalign_o),
        .state_o         (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic v,
                           input logic m, input logic [1:0] st);
        chk({tag, ".pc"},       pc_o,              pc);
        chk({tag, ".valid"},    {31'd0, pc_valid_o}, {31'd0, v});
        chk({tag, ".misalign"}, {31'd0, misalign_o}, {31'd0, m});
        chk({tag, ".state"},    {30'd0, state_o},    {30'd0, st});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pc_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        halt_i = 1'b0; resume_i = 1'b0;
`ifdef PC_RAS_EN
        call_i = 1'b0; ret_i = 1'b0;
`endif
        #12;
        chk_out("reset", 32'h0, 1'b0, 1'b0, 2'd0);

        // Reset release, continuous ready
        @(posedge clk); #1; rst = 1'b1;
        step(); chk_out("boot_run", 32'h0, 1'b1, 1'b0, 2'd1);
        step(); chk("adv4", pc_o, 32'h4);
        step(); chk("adv8", pc_o, 32'h8);
        pc_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out("stall", 32'h8, 1'b1, 1'b0, 2'd1);
        end
        pc_ready_i = 1'b1;
        step(); chk("advC", pc_o, 32'hC);

        // Redirects and misalignment trap
        pc_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step(); chk_out("redir100", 32'h100, 1'b1, 1'b0, 2'd1);
        redirect_pc_i = 32'h102;
        step(); chk_out("misalign", 32'h102, 1'b0, 1'b1, 2'd3);
        redirect_i = 1'b0; pc_ready_i = 1'b1;
        step(); chk_out("fault_hold", 32'h102, 1'b0, 1'b1, 2'd3);
        redirect_i = 1'b1; redirect_pc_i = 32'h200; pc_ready_i = 1'b0;
        step(); chk_out("fault_exit", 32'h200, 1'b1, 1'b0, 2'd1);

        // Halt with same-cycle handshake, resume
        redirect_pc_i = 32'h10;
        step(); chk("redir10", pc_o, 32'h10);
        redirect_i = 1'b0; pc_ready_i = 1'b1; halt_i = 1'b1;
        step(); chk_out("halt_adv", 32'h14, 1'b0, 1'b0, 2'd2);
        halt_i = 1'b0;
        step(); chk_out("halt_hold", 32'h14, 1'b0, 1'b0, 2'd2);
        resume_i = 1'b1;
        step(); chk_out("resume", 32'h14, 1'b1, 1'b0, 2'd1);
        resume_i = 1'b0; pc_ready_i = 1'b0; halt_i = 1'b1; resume_i = 1'b1;
        step(); chk_out("halt_wins_run", 32'h14, 1'b0, 1'b0, 2'd2);
        step(); chk_out("halt_wins_halt", 32'h14, 1'b0, 1'b0, 2'd2);
        halt_i = 1'b0; resume_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        step(); chk_out("redir_in_halt", 32'h300, 1'b0, 1'b0, 2'd2);
        redirect_i = 1'b0; resume_i = 1'b1;
        step(); chk_out("resume2", 32'h300, 1'b1, 1'b0, 2'd1);
        resume_i = 1'b0;

        // Address wrap and asynchronous reset
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step(); chk("top_addr", pc_o, 32'hFFFF_FFFC);
        redirect_i = 1'b0; pc_ready_i = 1'b1;
        step(); chk_out("wrap", 32'h0, 1'b1, 1'b0, 2'd1);
        step(); chk("post_wrap", pc_o, 32'h4);
        #2 rst = 1'b0;
        #1 chk_out("async_rst", 32'h0, 1'b0, 1'b0, 2'd0);

`ifdef PC_RAS_EN
        pc_ready_i = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        step(); chk_out("ras_boot", 32'h0, 1'b1, 1'b0, 2'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h20;
        step(); chk("ras_at20", pc_o, 32'h20);
        call_i = 1'b1; redirect_pc_i = 32'h400;
        step(); chk("call400", pc_o, 32'h400);
        call_i = 1'b0; redirect_i = 1'b0; ret_i = 1'b1;
        step(); chk("ret24", pc_o, 32'h24);
        chk("ret24.uf", {31'd0, ras_underflow_o}, 32'd0);
        pc_ready_i = 1'b1;
        step(); chk("uf_adv", pc_o, 32'h28);
        chk("uf_pulse", {31'd0, ras_underflow_o}, 32'd1);
        ret_i = 1'b0;
        step(); chk("uf_clear", {31'd0, ras_underflow_o}, 32'd0);
        chk("uf_adv2", pc_o, 32'h2C);
        // Five calls into a four-deep stack: return address 0x30 is lost
        pc_ready_i = 1'b0; redirect_i = 1'b1; call_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            redirect_pc_i = 32'h1000 * i;
            step(); chk("call_n", pc_o, 32'h1000 * i);
        end
        redirect_i = 1'b0; call_i = 1'b0; ret_i = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            step(); chk("ret_n", pc_o, 32'h1000 * i + 32'h4);
            chk("ret_n.uf", {31'd0, ras_underflow_o}, 32'd0);
        end
        step(); chk("ras_empty.pc", pc_o, 32'h1004);
        chk("ras_empty.uf", {31'd0, ras_underflow_o}, 32'd1);
        ret_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
